uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal write FIFO, runtime-selectable frame format (5 to DATA_W data bits, none/even/odd parity, 1 or 2 stop bits) and break generation. Sits between the processor output port and the serial TX pin, next to the baud-rate selector that supplies BAUD_COUNT. The producer loads bytes back-to-back until TX_RDY drops, and the block streams frames with no idle gap between them.

---
 rtl/uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with write FIFO, runtime frame format and break
//
// Purpose: buffers bytes from the processor output port in a DEPTH-entry FIFO
// and serialises them back-to-back on TX (start, 5..DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits). A BREAK request holds the line low.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   LOAD, OUT_PORT      one-cycle write strobe and data into the FIFO
//   BAUD_COUNT          bit period minus one, in clk cycles
//   DBITS, PEN, OHEL,   frame format: data bits, parity enable, odd parity,
//   STOP2               two stop bits (sampled when a frame starts)
//   BREAK               drive a break condition between frames
//   CLR_OVF             clear the sticky overflow flag
//   TX                  registered serial output, idles high
//   TX_RDY, TX_EMPTY    FIFO not full / FIFO empty and transmitter idle
//   FIFO_COUNT, OVF     FIFO occupancy / dropped-LOAD flag
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int BAUD_W = 19
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     LOAD,
  input  logic [DATA_W-1:0]        OUT_PORT,
  input  logic [BAUD_W-1:0]        BAUD_COUNT,
  input  logic [3:0]               DBITS,
  input  logic                     PEN,
  input  logic                     OHEL,
  input  logic                     STOP2,
  input  logic                     BREAK,
  input  logic                     CLR_OVF,
  output logic                     TX,
  output logic                     TX_RDY,
  output logic                     TX_EMPTY,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT,
  output logic                     OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MAX_BITS = 4'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;

  // Transmitter state
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic              tick;
  logic [DATA_W-1:0] shifter;
  logic [3:0]        nbits, bit_idx;
  logic              pen_l, stop2_l, par_l;
  logic              stop_idx;
  logic              brk_rel;
  logic              frame_done, enter_brk;
  logic [3:0]        dbits_eff;
  logic              par_new;
  logic              tx_q, ovf_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  // Full is judged before any same-cycle pop, so a LOAD into a full FIFO is
  // always dropped.
  assign push  = LOAD && !full;

  // >= rather than == so a BAUD_COUNT lowered mid-bit cannot strand the counter.
  assign tick = (baud_cnt >= BAUD_COUNT);

  assign frame_done = (state == STOP) && tick && (stop_idx || !stop2_l);
  // Break is honoured only between frames and outranks queued data.
  assign enter_brk  = BREAK && ((state == IDLE) || frame_done);
  assign pop        = !empty && !BREAK && ((state == IDLE) || frame_done);

  always_comb begin
    dbits_eff = DBITS;
    if (DBITS < 4'd5)
      dbits_eff = 4'd5;
    else if (DBITS > MAX_BITS)
      dbits_eff = MAX_BITS;
  end

  // Parity of the bits that will actually be sent, computed at pop time so the
  // data path needs no running accumulator.
  always_comb begin
    par_new = OHEL;
    for (int i = 0; i < DATA_W; i++)
      if (4'(i) < dbits_eff)
        par_new = par_new ^ head[i];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= OUT_PORT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (LOAD && full)
        ovf_q <= 1'b1;
      else if (CLR_OVF)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      shifter  <= '0;
      nbits    <= 4'd0;
      bit_idx  <= 4'd0;
      pen_l    <= 1'b0;
      stop2_l  <= 1'b0;
      par_l    <= 1'b0;
      stop_idx <= 1'b0;
      brk_rel  <= 1'b0;
    end else begin
      baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: ;
        START: begin
          if (tick) begin
            state   <= DATA;
            tx_q    <= shifter[0];
            shifter <= shifter >> 1;
            bit_idx <= 4'd0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == nbits - 4'd1) begin
              stop_idx <= 1'b0;
              if (pen_l) begin
                state <= PARITY;
                tx_q  <= par_l;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              tx_q    <= shifter[0];
              shifter <= shifter >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            tx_q     <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop2_l && !stop_idx)
              stop_idx <= 1'b1;
            else
              state <= IDLE;
          end
        end
        BRK: begin
          if (brk_rel) begin
            // One full high bit period after break release, then idle.
            if (tick)
              state <= IDLE;
          end else if (!BREAK) begin
            brk_rel  <= 1'b1;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase

      // Frame start and break entry share the IDLE and end-of-frame paths, so
      // they override whatever the case statement chose.
      if (enter_brk) begin
        state    <= BRK;
        tx_q     <= 1'b0;
        baud_cnt <= '0;
        brk_rel  <= 1'b0;
      end else if (pop) begin
        state    <= START;
        tx_q     <= 1'b0;
        baud_cnt <= '0;
        shifter  <= head;
        nbits    <= dbits_eff;
        pen_l    <= PEN;
        stop2_l  <= STOP2;
        par_l    <= par_new;
      end
    end
  end

  assign TX         = tx_q;
  assign TX_RDY     = !full;
  assign TX_EMPTY   = empty && (state == IDLE);
  assign FIFO_COUNT = count;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        LOAD = 1'b0;
  logic [7:0]  OUT_PORT = 8'h00;
  logic [18:0] BAUD_COUNT = 19'd3;
  logic [3:0]  DBITS = 4'd8;
  logic        PEN = 1'b0;
  logic        OHEL = 1'b0;
  logic        STOP2 = 1'b0;
  logic        BREAK = 1'b0;
  logic        CLR_OVF = 1'b0;
  logic        TX, TX_RDY, TX_EMPTY, OVF;
  logic [2:0]  FIFO_COUNT;

  int checks = 0;
  int errors = 0;
  int bc = 4;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .BAUD_W(19)) dut (
    .clk(clk), .reset_n(reset_n), .LOAD(LOAD), .OUT_PORT(OUT_PORT),
    .BAUD_COUNT(BAUD_COUNT), .DBITS(DBITS), .PEN(PEN), .OHEL(OHEL),
    .STOP2(STOP2), .BREAK(BREAK), .CLR_OVF(CLR_OVF), .TX(TX), .TX_RDY(TX_RDY),
    .TX_EMPTY(TX_EMPTY), .FIFO_COUNT(FIFO_COUNT), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fmt(input int baud, input int db, input bit pen, input bit ohel, input bit stop2);
    BAUD_COUNT = 19'(baud);
    DBITS = 4'(db);
    PEN = pen;
    OHEL = ohel;
    STOP2 = stop2;
    bc = baud + 1;
  endtask

  // Waits (bounded) for a start bit, then samples each bit in its middle.
  // Returns positioned at the middle of the last stop bit.
  task automatic rx_frame(input int nb, input bit pen, input int nstop,
                          output logic [8:0] data, output logic par,
                          output logic framing_ok, output int gap, output bit to);
    gap = 0; to = 1'b0; data = '0; par = 1'b0; framing_ok = 1'b1;
    while (TX !== 1'b0 && gap < 20 * bc + 100) begin
      step();
      gap++;
    end
    if (TX !== 1'b0) begin
      to = 1'b1;
      framing_ok = 1'b0;
      return;
    end
    repeat (bc / 2) step();
    if (TX !== 1'b0) framing_ok = 1'b0;
    for (int i = 0; i < nb; i++) begin
      repeat (bc) step();
      data[i] = TX;
    end
    if (pen) begin
      repeat (bc) step();
      par = TX;
    end
    for (int s = 0; s < nstop; s++) begin
      repeat (bc) step();
      if (TX !== 1'b1) framing_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
    checks++; if (TX_RDY !== 1'b1) begin errors++; $display("FAIL reset_tx_rdy: got %b expected 1", TX_RDY); end
    checks++; if (TX_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_tx_empty: got %b expected 1", TX_EMPTY); end
    checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", FIFO_COUNT); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [9:0] exp_bits;
    int bad;
    exp_bits = 10'b1101001010;
    bad = 0;
    set_fmt(3, 8, 0, 0, 0);
    step();
    LOAD = 1'b1; OUT_PORT = 8'hA5;
    step();
    LOAD = 1'b0;
    checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL single_count_k: got %0d expected 1", FIFO_COUNT); end
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL single_tx_k: got %b expected 1", TX); end
    step();
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL single_tx_fall: got %b expected 0", TX); end
    checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL single_count_k1: got %0d expected 0", FIFO_COUNT); end
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < 4; c++) begin
        if (TX !== exp_bits[j]) bad++;
        if (j == 9 && c == 3) begin
          checks++; if (TX_EMPTY !== 1'b0) begin errors++; $display("FAIL single_empty_early: got %b expected 0", TX_EMPTY); end
        end
        step();
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_bits: got %0d wrong cycles expected 0", bad); end
    checks++; if (TX_EMPTY !== 1'b1) begin errors++; $display("FAIL single_empty_40: got %b expected 1", TX_EMPTY); end
  endtask

  task automatic test_parity();
    logic [8:0] d; logic p, fok; int gap; bit to;
    // Even parity, 7 bits, two stop bits
    set_fmt(3, 7, 1, 0, 1);
    step();
    LOAD = 1'b1; OUT_PORT = 8'h41; step(); LOAD = 1'b0;
    rx_frame(7, 1, 2, d, p, fok, gap, to);
    checks++; if (d !== 9'h041 || to) begin errors++; $display("FAIL par_even_data: got %h expected 041", d); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL par_even_bit: got %b expected 0", p); end
    checks++; if (fok !== 1'b1) begin errors++; $display("FAIL par_even_framing: got %b expected 1", fok); end
    step();
    checks++; if (TX_EMPTY !== 1'b0) begin errors++; $display("FAIL par_stop2_len: got %b expected 0", TX_EMPTY); end
    step();
    checks++; if (TX_EMPTY !== 1'b1) begin errors++; $display("FAIL par_stop2_end: got %b expected 1", TX_EMPTY); end
    // Odd parity; format changed once the frame has started must not matter
    OHEL = 1'b1;
    step();
    LOAD = 1'b1; OUT_PORT = 8'h41; step(); LOAD = 1'b0;
    step();
    set_fmt(3, 5, 0, 0, 0);
    rx_frame(7, 1, 2, d, p, fok, gap, to);
    checks++; if (d !== 9'h041 || to) begin errors++; $display("FAIL par_odd_data: got %h expected 041", d); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL par_odd_bit: got %b expected 1", p); end
    checks++; if (fok !== 1'b1) begin errors++; $display("FAIL par_odd_framing: got %b expected 1", fok); end
    step();
    checks++; if (TX_EMPTY !== 1'b0) begin errors++; $display("FAIL par_latched_stop2: got %b expected 0", TX_EMPTY); end
    step();
    // DBITS below 5 clamps to 5
    set_fmt(3, 2, 1, 0, 0);
    step();
    LOAD = 1'b1; OUT_PORT = 8'h1F; step(); LOAD = 1'b0;
    rx_frame(5, 1, 1, d, p, fok, gap, to);
    checks++; if (d !== 9'h01F || p !== 1'b1 || fok !== 1'b1) begin errors++; $display("FAIL clamp_low: got data %h par %b framing %b expected 01f 1 1", d, p, fok); end
    repeat (2) step();
    // DBITS above DATA_W clamps to DATA_W
    set_fmt(3, 12, 1, 0, 0);
    step();
    LOAD = 1'b1; OUT_PORT = 8'h80; step(); LOAD = 1'b0;
    rx_frame(8, 1, 1, d, p, fok, gap, to);
    checks++; if (d !== 9'h080 || p !== 1'b1 || fok !== 1'b1) begin errors++; $display("FAIL clamp_high: got data %h par %b framing %b expected 080 1 1", d, p, fok); end
    repeat (2) step();
  endtask

  task automatic test_overflow();
    int exp_cnt [6];
    logic [8:0] d; logic p, fok; int gap; bit to;
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    set_fmt(100, 8, 0, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      LOAD = 1'b1; OUT_PORT = 8'(8'h10 + i);
      step();
      checks++; if (FIFO_COUNT !== 3'(exp_cnt[i])) begin errors++; $display("FAIL ovf_count_%0d: got %0d expected %0d", i, FIFO_COUNT, exp_cnt[i]); end
      if (i == 4) begin
        checks++; if (TX_RDY !== 1'b0 || OVF !== 1'b0) begin errors++; $display("FAIL ovf_full: got rdy %b ovf %b expected 0 0", TX_RDY, OVF); end
      end
    end
    LOAD = 1'b0;
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", OVF); end
    repeat (3) step();
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", OVF); end
    LOAD = 1'b1; CLR_OVF = 1'b1; step(); LOAD = 1'b0;
    checks++; if (OVF !== 1'b1 || FIFO_COUNT !== 3'd4) begin errors++; $display("FAIL ovf_wins: got ovf %b count %0d expected 1 4", OVF, FIFO_COUNT); end
    step();
    CLR_OVF = 1'b0;
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", OVF); end
    for (int i = 0; i < 5; i++) begin
      rx_frame(8, 0, 1, d, p, fok, gap, to);
      checks++; if (d !== 9'(8'h10 + i) || fok !== 1'b1 || to) begin errors++; $display("FAIL ovf_frame_%0d: got %h framing %b expected %h 1", i, d, fok, 8'h10 + i); end
      if (i >= 2) begin
        checks++; if (gap != bc - bc / 2) begin errors++; $display("FAIL ovf_gap_%0d: got %0d expected %0d", i, gap, bc - bc / 2); end
      end
    end
    repeat (bc - bc / 2) step();
    checks++; if (TX_EMPTY !== 1'b1 || FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL ovf_drained: got empty %b count %0d expected 1 0", TX_EMPTY, FIFO_COUNT); end
  endtask

  task automatic test_wraparound();
    int mism, gaps, tos, maxc;
    bit done;
    mism = 0; gaps = 0; tos = 0; maxc = 0; done = 1'b0;
    set_fmt(0, 8, 0, 0, 0);
    step();
    fork
      begin
        int n;
        n = 0;
        while (n < 12) begin
          if (TX_RDY === 1'b1) begin
            LOAD = 1'b1; OUT_PORT = 8'(8'h30 + n); n++;
          end else begin
            LOAD = 1'b0;
          end
          step();
        end
        LOAD = 1'b0;
      end
      begin
        logic [8:0] d; logic p, fok; int gap; bit to;
        for (int i = 0; i < 12; i++) begin
          rx_frame(8, 0, 1, d, p, fok, gap, to);
          if (to) tos++;
          if (d !== 9'(8'h30 + i) || fok !== 1'b1) mism++;
          if (i > 0 && gap != 1) gaps++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          if (int'(FIFO_COUNT) > maxc) maxc = int'(FIFO_COUNT);
          step();
        end
      end
    join
    checks++; if (mism != 0 || tos != 0) begin errors++; $display("FAIL wrap_data: got %0d bad frames %0d timeouts expected 0 0", mism, tos); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL wrap_gaps: got %0d gapped frames expected 0", gaps); end
    checks++; if (maxc != 4) begin errors++; $display("FAIL wrap_max_count: got %0d expected 4", maxc); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b expected 0", OVF); end
    step();
  endtask

  task automatic test_break();
    logic [7:0] d;
    logic stop_bit;
    logic [8:0] rd; logic p, fok; int gap, bad, n; bit to;
    set_fmt(3, 8, 0, 0, 0);
    step();
    LOAD = 1'b1; OUT_PORT = 8'h3C; step();
    OUT_PORT = 8'h5A; step();
    LOAD = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      repeat (4) step();
      d[i] = TX;
      if (i == 3) BREAK = 1'b1;
    end
    repeat (4) step();
    stop_bit = TX;
    checks++; if (d !== 8'h3C || stop_bit !== 1'b1) begin errors++; $display("FAIL brk_frame_done: got %h stop %b expected 3c 1", d, stop_bit); end
    repeat (2) step();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (TX !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL brk_low: got %0d high cycles expected 0", bad); end
    checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL brk_held: got %0d expected 1", FIFO_COUNT); end
    BREAK = 1'b0;
    step();
    n = 0;
    while (TX === 1'b1 && n < 50) begin
      n++;
      step();
    end
    checks++; if (n != bc + 1) begin errors++; $display("FAIL brk_release_len: got %0d expected %0d", n, bc + 1); end
    rx_frame(8, 0, 1, rd, p, fok, gap, to);
    checks++; if (rd !== 9'h05A || fok !== 1'b1 || to || gap != 0) begin errors++; $display("FAIL brk_queued_frame: got %h framing %b gap %0d expected 05a 1 0", rd, fok, gap); end
    repeat (2) step();
    checks++; if (TX_EMPTY !== 1'b1) begin errors++; $display("FAIL brk_end_empty: got %b expected 1", TX_EMPTY); end
  endtask

  task automatic test_async_reset();
    logic [8:0] d; logic p, fok; int gap; bit to;
    set_fmt(3, 8, 0, 0, 0);
    step();
    LOAD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      OUT_PORT = 8'(i);
      step();
    end
    LOAD = 1'b0;
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL arst_pre_ovf: got %b expected 1", OVF); end
    repeat (2) step();
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL arst_pre_tx: got %b expected 0", TX); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL arst_tx: got %b expected 1", TX); end
    checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", FIFO_COUNT); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b expected 0", OVF); end
    checks++; if (TX_RDY !== 1'b1 || TX_EMPTY !== 1'b1) begin errors++; $display("FAIL arst_flags: got rdy %b empty %b expected 1 1", TX_RDY, TX_EMPTY); end
    step();
    reset_n = 1'b1;
    step();
    LOAD = 1'b1; OUT_PORT = 8'h96; step(); LOAD = 1'b0;
    rx_frame(8, 0, 1, d, p, fok, gap, to);
    checks++; if (d !== 9'h096 || fok !== 1'b1 || to || gap != 1) begin errors++; $display("FAIL arst_fresh_frame: got %h framing %b gap %0d expected 096 1 1", d, fok, gap); end
    repeat (bc - bc / 2) step();
    checks++; if (TX_EMPTY !== 1'b1 || FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL arst_no_leftover: got empty %b count %0d expected 1 0", TX_EMPTY, FIFO_COUNT); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_overflow();
    test_wraparound();
    test_break();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
